hazard_unit_mc: RTL

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

---
 rtl/hazard_unit_mc_if.sv | 44 ++++
 rtl/hazard_unit_mc.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - pipeline hazard-unit signal bundle
// master drives stage information, slave (the hazard unit) returns stall/flush/forward controls.
interface hazard_unit_mc_if #(
  parameter int AW    = 5,
  parameter int LAT_W = 4,
  parameter int CNT_W = 16
);
  logic [AW-1:0]    Rs1_D, Rs2_D;
  logic [AW-1:0]    Rs1_E, Rs2_E, Rd_E;
  logic [1:0]       ResultSrc_E;
  logic             RegWrite_E;
  logic             PCSrc_E;
  logic             MultiStart_E;
  logic [LAT_W-1:0] MultiLat_E;
  logic [AW-1:0]    Rd_M;
  logic             RegWrite_M;
  logic             MemAccess_M;
  logic             DMemReady_M;
  logic [AW-1:0]    Rd_W;
  logic             RegWrite_W;
  logic             CntClear;
  logic [1:0]       ForwardA_E, ForwardB_E;
  logic             Stall_F, Stall_D, Stall_E, Stall_M;
  logic             Flush_D, Flush_E, Flush_M, Flush_W;
  logic             Busy;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E,
           MultiStart_E, MultiLat_E, Rd_M, RegWrite_M, MemAccess_M, DMemReady_M,
           Rd_W, RegWrite_W, CntClear,
    input  ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
           Flush_D, Flush_E, Flush_M, Flush_W, Busy, MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E,
           MultiStart_E, MultiLat_E, Rd_M, RegWrite_M, MemAccess_M, DMemReady_M,
           Rd_W, RegWrite_W, CntClear,
    output ForwardA_E, ForwardB_E, Stall_F, Stall_D, Stall_E, Stall_M,
           Flush_D, Flush_E, Flush_M, Flush_W, Busy, MemTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage pipeline hazard unit with multi-cycle execute and memory-wait watchdog
// Resolves RAW (forward or stall), load-use, branch flush, multi-cycle occupancy and memory back-pressure.
module hazard_unit_mc #(
  parameter int AW         = 5,
  parameter int LAT_W      = 4,
  parameter int FORWARD_EN = 1,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_mc_if.slave hz
);
  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, MULTI} state_t;

  state_t           state, state_n;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic [WC_W-1:0]  wait_cnt;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count, flush_count;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_stall, lw_stall, raw_stall, rs1_hit, rs2_hit, multi_stall;
  logic             stall_f, flush_d;

  assign mem_stall = hz.MemAccess_M & ~hz.DMemReady_M;

  assign lw_stall = (hz.ResultSrc_E == 2'b01) && (hz.Rd_E != '0) &&
                    ((hz.Rd_E == hz.Rs1_D) || (hz.Rd_E == hz.Rs2_D));

  // Writeback is not checked: the register file writes through to Decode reads.
  assign rs1_hit = (hz.Rs1_D != '0) && ((hz.RegWrite_E && hz.Rs1_D == hz.Rd_E) ||
                                        (hz.RegWrite_M && hz.Rs1_D == hz.Rd_M));
  assign rs2_hit = (hz.Rs2_D != '0) && ((hz.RegWrite_E && hz.Rs2_D == hz.Rd_E) ||
                                        (hz.RegWrite_M && hz.Rs2_D == hz.Rd_M));
  assign raw_stall = (FORWARD_EN == 0) && (rs1_hit || rs2_hit);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FORWARD_EN != 0) begin
      if (hz.Rs1_E != '0 && hz.RegWrite_M && hz.Rs1_E == hz.Rd_M)      fwd_a = 2'b10;
      else if (hz.Rs1_E != '0 && hz.RegWrite_W && hz.Rs1_E == hz.Rd_W) fwd_a = 2'b01;
      if (hz.Rs2_E != '0 && hz.RegWrite_M && hz.Rs2_E == hz.Rd_M)      fwd_b = 2'b10;
      else if (hz.Rs2_E != '0 && hz.RegWrite_W && hz.Rs2_E == hz.Rd_W) fwd_b = 2'b01;
    end
  end

  // cnt counts remaining Execute cycles; the op's last cycle (cnt==1) releases the stall.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    multi_stall = 1'b0;
    if (!mem_stall) begin
      case (state)
        IDLE: begin
          if (hz.MultiStart_E && hz.MultiLat_E >= LAT_W'(2)) begin
            multi_stall = 1'b1;
            cnt_n       = hz.MultiLat_E - LAT_W'(1);
            state_n     = MULTI;
          end
        end
        MULTI: begin
          if (cnt > LAT_W'(1)) begin
            multi_stall = 1'b1;
            cnt_n       = cnt - LAT_W'(1);
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_f    = 1'b0;
    flush_d    = 1'b0;
    hz.Stall_D = 1'b0;
    hz.Stall_E = 1'b0;
    hz.Stall_M = 1'b0;
    hz.Flush_E = 1'b0;
    hz.Flush_M = 1'b0;
    hz.Flush_W = 1'b0;
    if (rst) begin
      flush_d    = 1'b1;
      hz.Flush_E = 1'b1;
      hz.Flush_M = 1'b1;
      hz.Flush_W = 1'b1;
    end else if (mem_stall) begin
      stall_f    = 1'b1;
      hz.Stall_D = 1'b1;
      hz.Stall_E = 1'b1;
      hz.Stall_M = 1'b1;
      hz.Flush_W = 1'b1;
    end else if (multi_stall) begin
      stall_f    = 1'b1;
      hz.Stall_D = 1'b1;
      hz.Stall_E = 1'b1;
      hz.Flush_M = 1'b1;
    end else if (hz.PCSrc_E && state == IDLE) begin
      flush_d    = 1'b1;
      hz.Flush_E = 1'b1;
    end else if (lw_stall || raw_stall) begin
      stall_f    = 1'b1;
      hz.Stall_D = 1'b1;
      hz.Flush_E = 1'b1;
    end
  end

  assign hz.Stall_F    = stall_f;
  assign hz.Flush_D    = flush_d;
  assign hz.ForwardA_E = rst ? 2'b00 : fwd_a;
  assign hz.ForwardB_E = rst ? 2'b00 : fwd_b;
  assign hz.Busy       = (state == MULTI);
  assign hz.MemTimeout = mem_timeout;
  assign hz.StallCount = stall_count;
  assign hz.FlushCount = flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if (!mem_stall)          wait_cnt <= '0;
      else if (wait_cnt != '1) wait_cnt <= wait_cnt + WC_W'(1);
      if (TIMEOUT != 0 && mem_stall && wait_cnt == WC_W'(TIMEOUT - 1)) mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || hz.CntClear) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_f && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (flush_d && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule
